mcu_spi_tx: RTL and testbench
=============================

// Module: mcu_spi_tx
// PURPOSE
//  SPI-slave transmitter (mode 0, MSB first) returning PSRAM read data to the MCU over MCU_SPI_MISO.
//  Drains the PSRAM64 read FIFO (first-word-fall-through, read side on SYS_CLK) one byte per 8 SCLKs
//  while the MCU holds MCU_SPI_CS low. Pairs with the MOSI write path in PSRAM64.
//  MCU_RDY tells the MCU a burst is ready. SCLK and CS are oversampled; SYS_CLK >= 8 x SCLK.
// PARAMETERS
//  SYNC_STAGES  2      synchroniser depth for MCU_SPI_SCLK / MCU_SPI_CS (>=2)
//  IDLE_BYTE    8'hFF  byte shifted out on underrun
//  BURST_LEN    16     FIFO level at which MCU_RDY asserts
//  LEVEL_W      10     width of rd_level
//  CNT_W        16     width of frame_bytes
// PORTS
//  SYS_CLK          in   1        system clock (100 MHz)
//  SYS_RSTn         in   1        asynchronous active-low reset
//  MCU_SPI_SCLK     in   1        SPI clock from MCU, async, idles low
//  MCU_SPI_CS       in   1        SPI chip select from MCU, async, active low
//  MCU_SPI_MISO     out  1        serial data to MCU
//  MCU_SPI_MISO_OE  out  1        MISO output enable (top-level tristate)
//  MCU_RDY          out  1        registered: rd_level >= BURST_LEN
//  rd_data          in   8        FIFO head word, valid when rd_empty=0
//  rd_empty         in   1        FIFO empty
//  rd_level         in   LEVEL_W  FIFO occupancy
//  rd_req           out  1        one-cycle pop strobe
//  frame_bytes      out  CNT_W    bytes fully clocked in the current/last frame, saturating
//  underrun         out  1        sticky: filler byte sent in current/last frame
//  frame_active     out  1        synchronised CS is low
// BEHAVIOUR
//  Reset: MISO=1, MISO_OE=0, MCU_RDY=0, rd_req=0, frame_bytes=0, underrun=0, frame_active=0.
//   Sync chains reset to SCLK=0, CS=1, so no false edge on reset release. State IDLE.
//  Sync/edges: SYNC_STAGES flops, then one history flop. cs_fall, cs_rise, sck_rise, sck_fall are single-cycle pulses.
//  FSM IDLE -> LOAD on cs_fall.
//   LOAD (1 cycle), sequence:
//    - clear frame_bytes, underrun, bit_cnt;
//    - if !rd_empty: shreg<=rd_data, rd_req=1 this cycle;
//    - else shreg<=IDLE_BYTE, underrun<=1, no pop;
//    - MISO_OE<=1; enter SHIFT.
//  SHIFT:
//   - MISO = shreg[7] at all times.
//   - sck_rise: bit_cnt++ (3-bit). On wrap 7->0: byte complete, frame_bytes++ (saturate), need_load<=1.
//   - sck_fall, need_load=1: reload shreg as in LOAD (pop or IDLE_BYTE+underrun), clear need_load.
//   - sck_fall, need_load=0: shreg<=shreg<<1.
//   - cs_rise (any state): -> IDLE, MISO_OE<=0, MISO<=1, need_load<=0. No pop.
//     Partially sent byte is discarded (it was already popped). frame_bytes/underrun hold until next cs_fall.
//  Simultaneous events: cs_rise with sck_fall/sck_rise in the same cycle -> cs_rise wins, no pop/count.
//   cs_fall with SCLK edge -> edge ignored (LOAD).
//  SCLK edges while CS high are ignored.
//  rd_req is never asserted when rd_empty=1; at most one pop per byte.
//  Latency: MISO updates <= SYNC_STAGES+2 SYS_CLK after the SCLK fall. MCU must allow that before its next rise.
//   With SYNC_STAGES=2: SCLK <= SYS_CLK/8.
//  MCU_RDY: registered compare, 1-cycle latency. Independent of frame state.
//  Async reset mid-frame: immediate return to reset values. FIFO is not popped.
// TESTING
//  1 FIFO holds A5,3C; CS low, 16 SCLKs, CS high -> MISO bits 10100101 00111100; 2 rd_req pulses; frame_bytes=2, underrun=0.
//  2 FIFO holds 81 only; 16 SCLKs -> 10000001 then 11111111; underrun=1; frame_bytes=2; exactly 1 rd_req.
//  3 CS rises after 4 SCLKs -> frame_bytes=0, MISO_OE=0, MISO=1. Next frame sends the following FIFO byte, not a repeat.
//  4 CS rises in the same sync cycle as the 8th-bit fall -> no extra rd_req; frame_bytes=1.
//  5 rd_level 15->16->15 -> MCU_RDY 0->1->0, each one cycle after the level change. SCLK toggling with CS high -> no rd_req, MISO_OE=0.
//  6 SYS_RSTn low mid-byte -> all outputs reset at once. After release, a new frame starts cleanly at the next FIFO byte.

Source files
------------

// File: rtl/mcu_spi_tx.sv
// mcu_spi_tx: SPI-slave transmitter (mode 0, MSB first).
// Drains a first-word-fall-through read FIFO one byte per 8 SCLKs while the
// MCU holds CS low. SCLK and CS are oversampled on SYS_CLK.
module mcu_spi_tx #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [7:0]  IDLE_BYTE   = 8'hFF,
    parameter int          BURST_LEN   = 16,
    parameter int          LEVEL_W     = 10,
    parameter int          CNT_W       = 16
) (
    input  logic               SYS_CLK,
    input  logic               SYS_RSTn,
    input  logic               MCU_SPI_SCLK,
    input  logic               MCU_SPI_CS,
    output logic               MCU_SPI_MISO,
    output logic               MCU_SPI_MISO_OE,
    output logic               MCU_RDY,
    input  logic [7:0]         rd_data,
    input  logic               rd_empty,
    input  logic [LEVEL_W-1:0] rd_level,
    output logic               rd_req,
    output logic [CNT_W-1:0]   frame_bytes,
    output logic               underrun,
    output logic               frame_active
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } state_t;

    localparam logic [LEVEL_W-1:0] BURST_LVL = LEVEL_W'(BURST_LEN);

    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic                   sck_d;
    logic                   cs_d;
    logic                   sck_s;
    logic                   cs_s;
    logic                   sck_rise;
    logic                   sck_fall;
    logic                   cs_rise;
    logic                   cs_fall;

    state_t                 state;
    state_t                 state_next;
    logic                   load_byte;
    logic [7:0]             shreg;
    logic [2:0]             bit_cnt;
    logic                   need_load;

    // Synchronise SCLK/CS and keep one history flop each for edge detection.
    always_ff @(posedge SYS_CLK or negedge SYS_RSTn) begin
        if (!SYS_RSTn) begin
            // NOTE: chains reset to the idle bus levels (SCLK low, CS high) so
            // releasing reset can never look like an edge.
            sck_sync <= '0;
            cs_sync  <= '1;
            sck_d    <= 1'b0;
            cs_d     <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the
            // pre-edge value, which is what makes the chain a shift register.
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], MCU_SPI_SCLK};
            cs_sync  <= {cs_sync[SYNC_STAGES-2:0], MCU_SPI_CS};
            sck_d    <= sck_sync[SYNC_STAGES-1];
            cs_d     <= cs_sync[SYNC_STAGES-1];
        end
    end

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign sck_rise =  sck_s & ~sck_d;
    assign sck_fall = ~sck_s &  sck_d;
    assign cs_rise  =  cs_s  & ~cs_d;
    assign cs_fall  = ~cs_s  &  cs_d;

    assign frame_active = ~cs_s;

    // State register.
    always_ff @(posedge SYS_CLK or negedge SYS_RSTn) begin
        if (!SYS_RSTn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and byte-load/pop strobe; cs_rise overrides any SCLK edge.
    always_comb begin
        // NOTE: defaults first so every path assigns every output (no latches).
        state_next = state;
        load_byte  = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall) state_next = LOAD;
            end
            LOAD: begin
                if (cs_rise) begin
                    state_next = IDLE;
                end else begin
                    state_next = SHIFT;
                    load_byte  = 1'b1;
                end
            end
            SHIFT: begin
                if (cs_rise) state_next = IDLE;
                else if (sck_fall && need_load) load_byte = 1'b1;
            end
            default: state_next = IDLE;
        endcase
        rd_req = load_byte & ~rd_empty;
    end

    // Shift register, bit/byte counters, underrun flag and output enable.
    always_ff @(posedge SYS_CLK or negedge SYS_RSTn) begin
        if (!SYS_RSTn) begin
            shreg           <= '1;
            bit_cnt         <= '0;
            need_load       <= 1'b0;
            frame_bytes     <= '0;
            underrun        <= 1'b0;
            MCU_SPI_MISO_OE <= 1'b0;
        end else if (cs_rise) begin
            // A partially shifted byte is dropped; counters hold for readback.
            MCU_SPI_MISO_OE <= 1'b0;
            need_load       <= 1'b0;
        end else if (state == LOAD) begin
            frame_bytes     <= '0;
            bit_cnt         <= '0;
            need_load       <= 1'b0;
            shreg           <= rd_empty ? IDLE_BYTE : rd_data;
            underrun        <= rd_empty;
            MCU_SPI_MISO_OE <= 1'b1;
        end else if (state == SHIFT) begin
            if (sck_rise) begin
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    need_load <= 1'b1;
                    if (frame_bytes != '1) frame_bytes <= frame_bytes + CNT_W'(1);
                end
            end
            if (sck_fall) begin
                if (need_load) begin
                    shreg     <= rd_empty ? IDLE_BYTE : rd_data;
                    underrun  <= underrun | rd_empty;
                    need_load <= 1'b0;
                end else begin
                    shreg <= {shreg[6:0], 1'b0};
                end
            end
        end
    end

    assign MCU_SPI_MISO = (state == SHIFT) ? shreg[7] : 1'b1;

    // Burst-ready flag: registered level compare, independent of frame state.
    always_ff @(posedge SYS_CLK or negedge SYS_RSTn) begin
        if (!SYS_RSTn) begin
            MCU_RDY <= 1'b0;
        end else begin
            MCU_RDY <= (rd_level >= BURST_LVL);
        end
    end

endmodule

// File: tb/tb_mcu_spi_tx.sv
// tb_mcu_spi_tx: randomized SPI frames against a byte-level reference model,
// with a bus monitor comparing received MISO bytes from a scoreboard queue.
`timescale 1ns/1ps
module tb_mcu_spi_tx;

    localparam int         LEVEL_W   = 10;
    localparam int         CNT_W     = 16;
    localparam logic [7:0] IDLE_BYTE = 8'hFF;
    localparam int         HALF      = 6;

    logic               clk = 1'b0;
    logic               SYS_RSTn;
    logic               MCU_SPI_SCLK;
    logic               MCU_SPI_CS;
    logic               MCU_SPI_MISO;
    logic               MCU_SPI_MISO_OE;
    logic               MCU_RDY;
    logic [7:0]         rd_data;
    logic               rd_empty;
    logic [LEVEL_W-1:0] rd_level;
    logic               rd_req;
    logic [CNT_W-1:0]   frame_bytes;
    logic               underrun;
    logic               frame_active;

    logic [7:0] fifo[$];
    logic [7:0] exp_q[$];
    int         n_cmp   = 0;
    int         n_fail  = 0;
    int         pop_cnt = 0;

    always #5 clk = ~clk;

    mcu_spi_tx #(
        .SYNC_STAGES(2), .IDLE_BYTE(IDLE_BYTE), .BURST_LEN(16),
        .LEVEL_W(LEVEL_W), .CNT_W(CNT_W)
    ) dut (
        .SYS_CLK(clk), .SYS_RSTn(SYS_RSTn),
        .MCU_SPI_SCLK(MCU_SPI_SCLK), .MCU_SPI_CS(MCU_SPI_CS),
        .MCU_SPI_MISO(MCU_SPI_MISO), .MCU_SPI_MISO_OE(MCU_SPI_MISO_OE),
        .MCU_RDY(MCU_RDY), .rd_data(rd_data), .rd_empty(rd_empty),
        .rd_level(rd_level), .rd_req(rd_req), .frame_bytes(frame_bytes),
        .underrun(underrun), .frame_active(frame_active)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic update_fifo_ports();
        rd_empty = (fifo.size() == 0);
        rd_level = LEVEL_W'(fifo.size());
        if (fifo.size() != 0) rd_data = fifo[0];
        else rd_data = 8'h00;
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sck_pulse(input bit last);
        MCU_SPI_SCLK = 1'b1;
        wait_clk(HALF);
        MCU_SPI_SCLK = 1'b0;
        if (last) MCU_SPI_CS = 1'b1;
        wait_clk(HALF);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_miso"},    32'(MCU_SPI_MISO),    32'd1);
        check({tag, "_oe"},      32'(MCU_SPI_MISO_OE), 32'd0);
        check({tag, "_rdy"},     32'(MCU_RDY),         32'd0);
        check({tag, "_rd_req"},  32'(rd_req),          32'd0);
        check({tag, "_fbytes"},  32'(frame_bytes),     32'd0);
        check({tag, "_underrun"},32'(underrun),        32'd0);
        check({tag, "_active"},  32'(frame_active),    32'd0);
    endtask

    // Frame of n SCLK pulses; the last fall coincides with CS rising.
    // A byte is loaded at frame start and after every completed byte that
    // still has a following fall, each from the FIFO or as filler.
    task automatic run_frame(input int n);
        int avail, loads, exp_pops, pops0;
        bit exp_under;
        avail     = fifo.size();
        loads     = 1 + ((n > 0) ? (n - 1) / 8 : 0);
        exp_pops  = (loads < avail) ? loads : avail;
        exp_under = (loads > avail);
        for (int j = 0; j < n / 8; j++)
            exp_q.push_back((j < avail) ? fifo[j] : IDLE_BYTE);
        pops0 = pop_cnt;
        MCU_SPI_CS = 1'b0;
        wait_clk(10);
        check("oe_in_frame", 32'(MCU_SPI_MISO_OE), 32'd1);
        check("active_in_frame", 32'(frame_active), 32'd1);
        if (n == 0) MCU_SPI_CS = 1'b1;
        for (int i = 0; i < n; i++) sck_pulse(i == n - 1);
        wait_clk(8);
        check("frame_bytes", 32'(frame_bytes), 32'(n / 8));
        check("underrun", 32'(underrun), 32'(exp_under));
        check("pop_count", 32'(pop_cnt - pops0), 32'(exp_pops));
        check("oe_after", 32'(MCU_SPI_MISO_OE), 32'd0);
        check("miso_after", 32'(MCU_SPI_MISO), 32'd1);
        check("active_after", 32'(frame_active), 32'd0);
        check("bytes_outstanding", 32'(exp_q.size()), 32'd0);
    endtask

    // FIFO read side: pop on a sampled rd_req at the following clock edge.
    initial begin : fifo_side
        logic p, p_prev;
        p_prev = 1'b0;
        forever begin
            @(negedge clk);
            p = rd_req;
            if (p === 1'b1) begin
                check("rd_req_when_empty", 32'(rd_empty), 32'd0);
                check("rd_req_single_cycle", 32'(p_prev), 32'd0);
            end
            p_prev = p;
            @(posedge clk);
            #1;
            if (p === 1'b1 && SYS_RSTn) begin
                void'(fifo.pop_front());
                pop_cnt++;
                update_fifo_ports();
            end
        end
    end

    // Bus monitor: sample MISO on SCLK rise while CS low, compare whole bytes.
    initial begin : monitor
        logic [7:0] sh;
        int bits;
        bits = 0;
        sh   = '0;
        forever begin
            @(posedge MCU_SPI_SCLK or posedge MCU_SPI_CS or negedge SYS_RSTn);
            if (MCU_SPI_CS || !SYS_RSTn) begin
                bits = 0;
            end else begin
                sh = {sh[6:0], MCU_SPI_MISO};
                bits++;
                if (bits == 8) begin
                    bits = 0;
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_byte: got %0h, expected none", sh);
                    end else begin
                        check("miso_byte", 32'(sh), 32'(exp_q.pop_front()));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int p0;
        SYS_RSTn     = 1'b1;
        MCU_SPI_CS   = 1'b1;
        MCU_SPI_SCLK = 1'b0;
        update_fifo_ports();
        #1 SYS_RSTn = 1'b0;
        wait_clk(3);
        check_reset_outputs("reset");
        SYS_RSTn = 1'b1;
        wait_clk(3);

        // Two full bytes, FIFO exactly covers the frame.
        fifo = '{8'hA5, 8'h3C};
        update_fifo_ports();
        run_frame(16);

        // Second byte is filler.
        fifo = '{8'h81};
        update_fifo_ports();
        run_frame(16);

        // Aborted frame, next frame must send the following byte.
        fifo = '{8'h11, 8'h22};
        update_fifo_ports();
        run_frame(4);
        run_frame(8);

        // CS rises together with the 8th fall: no extra pop.
        fifo = '{8'h5A, 8'hC3};
        update_fifo_ports();
        run_frame(8);
        fifo.delete();
        update_fifo_ports();

        // MCU_RDY threshold with one-cycle latency.
        repeat (15) fifo.push_back(8'($urandom));
        update_fifo_ports();
        wait_clk(2);
        check("rdy_at_15", 32'(MCU_RDY), 32'd0);
        fifo.push_back(8'($urandom));
        update_fifo_ports();
        @(negedge clk);
        check("rdy_before_latency", 32'(MCU_RDY), 32'd0);
        wait_clk(1);
        check("rdy_at_16", 32'(MCU_RDY), 32'd1);
        void'(fifo.pop_back());
        update_fifo_ports();
        @(negedge clk);
        check("rdy_hold", 32'(MCU_RDY), 32'd1);
        wait_clk(1);
        check("rdy_back_15", 32'(MCU_RDY), 32'd0);

        // SCLK activity with CS high is ignored.
        p0 = pop_cnt;
        repeat (6) begin
            MCU_SPI_SCLK = 1'b1;
            wait_clk(3);
            check("oe_cs_high", 32'(MCU_SPI_MISO_OE), 32'd0);
            MCU_SPI_SCLK = 1'b0;
            wait_clk(3);
        end
        check("pops_cs_high", 32'(pop_cnt - p0), 32'd0);

        // Randomized frames.
        repeat (10) begin
            int k;
            k = $urandom_range(0, 3);
            repeat (k) fifo.push_back(8'($urandom));
            update_fifo_ports();
            run_frame($urandom_range(1, 24));
        end

        // Reset in the middle of a byte.
        fifo.push_back(8'($urandom));
        fifo.push_back(8'($urandom));
        update_fifo_ports();
        p0 = pop_cnt;
        MCU_SPI_CS = 1'b0;
        wait_clk(10);
        repeat (4) sck_pulse(1'b0);
        @(posedge clk);
        #3 SYS_RSTn = 1'b0;
        #1;
        check_reset_outputs("midreset");
        MCU_SPI_CS = 1'b1;
        wait_clk(4);
        check("midreset_pops", 32'(pop_cnt - p0), 32'd1);
        SYS_RSTn = 1'b1;
        wait_clk(4);
        run_frame(8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
